mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between EXE and WB. Latches one instruction from EXE, waits for the data-SRAM response of any load or store that EXE issued, and extracts and sign- or zero-extends load data. Hands the completed result to WB over the valid/allowin handshake. Tracks requests orphaned by a WB flush and discards their responses so they cannot corrupt later instructions.

## Interface
Parameters:
- ES_BUS_W, 75: EXE→MEM bus width; layout {req_sent[74], ld_op[73:71], ex_in[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}.
- WS_BUS_W, 71: MEM→WB bus width; layout {ex[70], gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.

Ports:
- clk  in  1  clock; everything samples on posedge.
- reset  in  1  synchronous, active-high reset.
- ms_allowin  out  1  MEM can accept from EXE this cycle.
- es_to_ms_valid  in  1  EXE bus valid.
- es_to_ms_bus  in  ES_BUS_W  EXE payload.
- ws_allowin  in  1  WB can accept.
- ms_to_ws_valid  out  1  MEM payload valid to WB.
- ms_to_ws_bus  out  WS_BUS_W  MEM payload.
- data_sram_data_ok  in  1  one-cycle response pulse for an outstanding data request.
- data_sram_rdata  in  32  read data, valid with data_ok.
- wb_flush  in  1  WB exception, ertn or refetch; kills the MEM instruction.
- ms_ex  out  1  ms_valid & ex_in; EXE uses it to suppress new stores.
- ms_fwd_bus  out  39  {ms_valid&gr_we, ms_ready_go, dest[4:0], final_result[31:0]} for bypass/interlock.

## Operation
- ld_op encoding: 000 none/word, 001 ld.b, 010 ld.h, 011 ld.bu, 100 ld.hu. Byte lane is result[1:0]; halfword lane is result[1]. For ld.w and stores, final_result = rdata or result respectively.
- A store with req_sent=1 still waits for data_ok; final_result = result.
- If req_sent=0, final_result = result and the instruction is ready immediately.
- If ex_in=1, there is no wait, ex is forwarded unchanged, and gr_we is passed through; WB gates the write.
- States:
  - EMPTY: ms_valid=0.
  - WAIT: valid, req_sent, no data yet.
  - READY: valid, result final.
  - CANCEL: no valid instruction; one orphaned response still due.
- Transitions:
  - EMPTY→WAIT or READY on accept, chosen by req_sent.
  - WAIT→READY on data_ok.
  - READY→EMPTY when ws_allowin and there is no new accept. On a simultaneous accept, go to WAIT or READY by the new req_sent.
  - Any valid state with wb_flush → EMPTY. Exception: from WAIT with data_ok low, go → CANCEL.
  - CANCEL→EMPTY on data_ok; the data is discarded.
- ms_ready_go = (state==READY) | (state==WAIT & data_ok).
- ms_allowin = (state==EMPTY) | (ms_ready_go & ws_allowin). It is forced to 0 in CANCEL and in any cycle with wb_flush.
- ms_to_ws_valid = ms_valid & ms_ready_go & ~wb_flush.
- Reset: state EMPTY, ms_allowin=1, ms_to_ws_valid=0, ms_ex=0, ms_fwd_bus all-zero. Reset mid-WAIT or mid-CANCEL also returns to EMPTY; the SRAM side is reset in the same cycle.

## Timing
- Payload is registered on es_to_ms_valid & ms_allowin and visible the next cycle.
- Latency:
  - Non-memory instructions: 1 cycle through MEM.
  - Memory instructions: 1 cycle plus data_ok delay. A data_ok in the first WAIT cycle completes in that same cycle.
- data_sram_rdata is used only in the data_ok cycle, or from the buffer (see Configuration).
- wb_flush dominates accept: an instruction offered in the flush cycle is not latched.
- At most one outstanding request is tracked. A second data_ok during CANCEL is a protocol violation.

## Configuration
- MEM_RDATA_BUF_EN defined:
  - On data_ok in WAIT, the extracted load result is stored in a 32-bit register and the stage enters READY.
  - The stage then holds that result for any number of ws_allowin=0 cycles.
- Undefined:
  - No buffer; final_result is taken combinationally from data_sram_rdata.
  - In WAIT, data_ok with ws_allowin=0 is illegal. An assertion fires in simulation, and this configuration requires WB to keep ws_allowin tied high.

## Test plan
- ALU op: result=0x1234 and req_sent=0 accepted at cycle n → ms_to_ws_valid=1 at n+1 with final_result=0x1234.
- ld.b with result[1:0]=2, rdata=0x00A50000, data_ok 3 cycles later → final_result=0xFFFFFFA5. The same with ld.bu → 0x000000A5.
- ld.h with result[1]=1, rdata=0x80010000 → 0xFFFF8001; ld.w → rdata unchanged. Back-to-back accepts while ws_allowin=1 yield one result per data_ok.
- wb_flush during WAIT with no data_ok → state CANCEL and ms_allowin=0. The next data_ok (rdata=0xDEADBEEF) is dropped, ms_to_ws_valid stays 0, and the stage returns to EMPTY.
- MEM_RDATA_BUF_EN: data_ok with ws_allowin=0 for 4 cycles → result held. On ws_allowin=1, exactly one transfer occurs with the correct data.
- Reset asserted during WAIT → next cycle EMPTY, ms_allowin=1, ms_to_ws_valid=0, and a later stray data_ok is ignored.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; waits for data-SRAM responses, extends load data and drops responses orphaned by a flush.
// Define MEM_RDATA_BUF_EN to register load data so it can be held while WB stalls.
module mem_stage #(
  parameter int ES_BUS_W = 75,
  parameter int WS_BUS_W = 71
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ms_allowin,
  input  logic                es_to_ms_valid,
  input  logic [ES_BUS_W-1:0] es_to_ms_bus,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [WS_BUS_W-1:0] ms_to_ws_bus,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                wb_flush,
  output logic                ms_ex,
  output logic [38:0]         ms_fwd_bus
);
  typedef enum logic [1:0] {EMPTY, WAIT, READY, CANCEL} state_t;
  state_t state, state_nxt;
  logic [ES_BUS_W-1:0] es_bus;
  logic        req_sent, ex_in, gr_we, ms_valid, ms_ready_go, accept, new_wait, is_load;
  logic [2:0]  ld_op;
  logic [4:0]  dest;
  logic [31:0] result, pc, ld_val, final_result;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  assign {req_sent, ld_op, ex_in, gr_we, dest, result, pc} = es_bus;
  assign ms_valid    = state == WAIT || state == READY;
  assign ms_ready_go = state == READY || (state == WAIT && data_sram_data_ok);
  assign ms_allowin  = !wb_flush && state != CANCEL && (state == EMPTY || (ms_ready_go && ws_allowin));
  assign accept      = es_to_ms_valid && ms_allowin;
  assign new_wait    = es_to_ms_bus[74] && !es_to_ms_bus[70];
  // Stores carry gr_we=0, which is what separates them from ld.w (both ld_op=000).
  assign is_load     = req_sent && !ex_in && (gr_we || ld_op != 3'd0);
  assign byte_v      = data_sram_rdata[result[1:0]*8 +: 8];
  assign half_v      = result[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
  assign ld_val      = ld_op == 3'd1 ? {{24{byte_v[7]}}, byte_v} :
                       ld_op == 3'd2 ? {{16{half_v[15]}}, half_v} :
                       ld_op == 3'd3 ? {24'd0, byte_v} :
                       ld_op == 3'd4 ? {16'd0, half_v} : data_sram_rdata;
  assign state_nxt   = state == CANCEL ? (data_sram_data_ok ? EMPTY : CANCEL) :
                       wb_flush ? ((state == WAIT && !data_sram_data_ok) ? CANCEL : EMPTY) :
                       accept ? (new_wait ? WAIT : READY) :
                       (ms_ready_go && ws_allowin) ? EMPTY :
                       (state == WAIT && data_sram_data_ok) ? READY : state;
`ifdef MEM_RDATA_BUF_EN
  logic [31:0] rdata_buf;
  always_ff @(posedge clk) begin
    if (reset) rdata_buf <= '0;
    else if (state == WAIT && data_sram_data_ok) rdata_buf <= ld_val;
  end
  assign final_result = is_load ? (state == WAIT ? ld_val : rdata_buf) : result;
`else
  assign final_result = is_load ? ld_val : result;
  // Without the buffer the response is lost unless WB takes it in the same cycle.
  assert property (@(posedge clk) disable iff (reset)
    !(state == WAIT && data_sram_data_ok && !ws_allowin && !wb_flush));
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      es_bus <= '0;
    end else begin
      state <= state_nxt;
      if (accept) es_bus <= es_to_ms_bus;
    end
  end
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !wb_flush;
  assign ms_to_ws_bus   = {ex_in, gr_we, dest, final_result, pc};
  assign ms_ex          = ms_valid && ex_in;
  assign ms_fwd_bus     = {ms_valid && gr_we, ms_ready_go, dest, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
  logic        clk = 0, reset = 1, es_to_ms_valid = 0, ws_allowin = 1;
  logic        data_sram_data_ok = 0, wb_flush = 0;
  logic [74:0] es_to_ms_bus = '0;
  logic [31:0] data_sram_rdata = '0;
  logic        ms_allowin, ms_to_ws_valid, ms_ex;
  logic [70:0] ms_to_ws_bus;
  logic [38:0] ms_fwd_bus;
  int checks = 0, errors = 0;
  mem_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
    .es_to_ms_bus(es_to_ms_bus), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .wb_flush(wb_flush), .ms_ex(ms_ex), .ms_fwd_bus(ms_fwd_bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [74:0] mk(input logic req, input logic [2:0] ld, input logic ex, input logic we,
                                     input logic [4:0] d, input logic [31:0] r, input logic [31:0] pc);
    return {req, ld, ex, we, d, r, pc};
  endfunction
  task automatic load(input string tag, input logic [74:0] b, input logic [31:0] rd, input int dly,
                      input logic [31:0] exp);
    @(negedge clk) es_to_ms_valid = 1; es_to_ms_bus = b;
    @(negedge clk) es_to_ms_valid = 0; #1;
    check({tag, "_wait_valid"}, ms_to_ws_valid, 0);
    check({tag, "_wait_allowin"}, ms_allowin, 0);
    repeat (dly - 1) @(negedge clk);
    data_sram_data_ok = 1; data_sram_rdata = rd; #1;
    check({tag, "_valid"}, ms_to_ws_valid, 1);
    check({tag, "_result"}, ms_to_ws_bus[63:32], exp);
    @(negedge clk) data_sram_data_ok = 0; data_sram_rdata = '0; #1;
    check({tag, "_drained"}, ms_to_ws_valid, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0; #1;
    check("rst_allowin", ms_allowin, 1);
    check("rst_valid", ms_to_ws_valid, 0);
    check("rst_ex", ms_ex, 0);
    check("rst_fwd", ms_fwd_bus, 0);
    // ALU op: one cycle through MEM
    @(negedge clk) es_to_ms_valid = 1; es_to_ms_bus = mk(0, 3'd0, 0, 1, 5'd5, 32'h1234, 32'h100); #1;
    check("alu_allowin", ms_allowin, 1);
    @(negedge clk) es_to_ms_valid = 0; #1;
    check("alu_valid", ms_to_ws_valid, 1);
    check("alu_bus", ms_to_ws_bus, {1'b0, 1'b1, 5'd5, 32'h1234, 32'h100});
    check("alu_fwd", ms_fwd_bus, {1'b1, 1'b1, 5'd5, 32'h1234});
    @(negedge clk) #1;
    check("alu_gone", ms_to_ws_valid, 0);
    load("ldb",  mk(1, 3'd1, 0, 1, 5'd3, 32'h1002, 32'h104), 32'h00A50000, 3, 32'hFFFFFFA5);
    load("ldbu", mk(1, 3'd3, 0, 1, 5'd3, 32'h1002, 32'h108), 32'h00A50000, 3, 32'h000000A5);
    load("ldh",  mk(1, 3'd2, 0, 1, 5'd4, 32'h1002, 32'h10C), 32'h80010000, 2, 32'hFFFF8001);
    load("ldhu", mk(1, 3'd4, 0, 1, 5'd4, 32'h1002, 32'h110), 32'h80010000, 1, 32'h00008001);
    load("ldw",  mk(1, 3'd0, 0, 1, 5'd6, 32'h1000, 32'h114), 32'h80010000, 1, 32'h80010000);
    load("st",   mk(1, 3'd0, 0, 0, 5'd0, 32'h2000, 32'h118), 32'hFFFFFFFF, 2, 32'h00002000);
    // back-to-back loads, each completing in its first WAIT cycle
    @(negedge clk) es_to_ms_valid = 1; es_to_ms_bus = mk(1, 3'd0, 0, 1, 5'd7, 32'h3000, 32'h120);
    @(negedge clk) es_to_ms_bus = mk(1, 3'd3, 0, 1, 5'd8, 32'h3001, 32'h124);
    data_sram_data_ok = 1; data_sram_rdata = 32'h11111111; #1;
    check("b2b_allowin", ms_allowin, 1);
    check("b2b1_valid", ms_to_ws_valid, 1);
    check("b2b1_result", ms_to_ws_bus[63:32], 32'h11111111);
    @(negedge clk) es_to_ms_valid = 0; data_sram_rdata = 32'h33332222; #1;
    check("b2b2_valid", ms_to_ws_valid, 1);
    check("b2b2_result", ms_to_ws_bus[63:32], 32'h00000022);
    check("b2b2_pc", ms_to_ws_bus[31:0], 32'h124);
    @(negedge clk) data_sram_data_ok = 0; #1;
    check("b2b_done", ms_to_ws_valid, 0);
    // flush during WAIT orphans the request
    @(negedge clk) es_to_ms_valid = 1; es_to_ms_bus = mk(1, 3'd0, 0, 1, 5'd9, 32'h4000, 32'h130);
    @(negedge clk) es_to_ms_valid = 0; wb_flush = 1; #1;
    check("fl_allowin", ms_allowin, 0);
    check("fl_valid", ms_to_ws_valid, 0);
    @(negedge clk) wb_flush = 0; es_to_ms_valid = 1; es_to_ms_bus = mk(0, 3'd0, 0, 1, 5'd10, 32'h5555, 32'h134); #1;
    check("cancel_allowin", ms_allowin, 0);
    check("cancel_valid", ms_to_ws_valid, 0);
    @(negedge clk) data_sram_data_ok = 1; data_sram_rdata = 32'hDEADBEEF; #1;
    check("cancel_drop_valid", ms_to_ws_valid, 0);
    check("cancel_drop_allowin", ms_allowin, 0);
    @(negedge clk) data_sram_data_ok = 0; #1;
    check("cancel_empty_allowin", ms_allowin, 1);
    check("cancel_empty_valid", ms_to_ws_valid, 0);
    @(negedge clk) es_to_ms_valid = 0; #1;
    check("post_cancel_valid", ms_to_ws_valid, 1);
    check("post_cancel_result", ms_to_ws_bus[63:32], 32'h5555);
    // exception instruction: no wait, ex forwarded
    @(negedge clk) es_to_ms_valid = 1; es_to_ms_bus = mk(1, 3'd0, 1, 1, 5'd11, 32'h6000, 32'h140);
    @(negedge clk) es_to_ms_valid = 0; #1;
    check("ex_ms_ex", ms_ex, 1);
    check("ex_valid", ms_to_ws_valid, 1);
    check("ex_bus", ms_to_ws_bus, {1'b1, 1'b1, 5'd11, 32'h6000, 32'h140});
    @(negedge clk) #1;
    check("ex_clear", ms_ex, 0);
    // reset mid-WAIT
    @(negedge clk) es_to_ms_valid = 1; es_to_ms_bus = mk(1, 3'd0, 0, 1, 5'd12, 32'h7000, 32'h150);
    @(negedge clk) es_to_ms_valid = 0; reset = 1;
    @(negedge clk) reset = 0; #1;
    check("rw_allowin", ms_allowin, 1);
    check("rw_valid", ms_to_ws_valid, 0);
    check("rw_fwd", ms_fwd_bus, 0);
    @(negedge clk) data_sram_data_ok = 1; data_sram_rdata = 32'hCAFEF00D; #1;
    check("rw_stray_valid", ms_to_ws_valid, 0);
    check("rw_stray_allowin", ms_allowin, 1);
    @(negedge clk) data_sram_data_ok = 0;
`ifdef MEM_RDATA_BUF_EN
    @(negedge clk) es_to_ms_valid = 1; es_to_ms_bus = mk(1, 3'd1, 0, 1, 5'd13, 32'h8003, 32'h160);
    @(negedge clk) es_to_ms_valid = 0; ws_allowin = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h7F000000; #1;
    check("buf_ok_result", ms_to_ws_bus[63:32], 32'h0000007F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) data_sram_data_ok = 0; data_sram_rdata = '0; #1;
      check("buf_hold_valid", ms_to_ws_valid, 1);
      check("buf_hold_result", ms_to_ws_bus[63:32], 32'h0000007F);
    end
    @(negedge clk) ws_allowin = 1; #1;
    check("buf_xfer_valid", ms_to_ws_valid, 1);
    check("buf_xfer_result", ms_to_ws_bus[63:32], 32'h0000007F);
    @(negedge clk) #1;
    check("buf_single", ms_to_ws_valid, 0);
`endif
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
